// File: rtl/game_score_if.sv
// Game-flow controller bus: frame tick, start, miss pulses in;
// scores, ball control and match status out.
interface game_score_if #(
    parameter int SCORE_W = 4
);
    logic               i_timing_tick;
    logic               i_start_btn;
    logic               i_miss_left;
    logic               i_miss_right;
    logic [SCORE_W-1:0] o_score_left;
    logic [SCORE_W-1:0] o_score_right;
    logic               o_ball_enable;
    logic               o_ball_reset;
    logic               o_serve_right;
    logic               o_point_pulse;
    logic               o_game_over;
    logic               o_winner_right;

    modport master (
        output i_timing_tick, i_start_btn, i_miss_left, i_miss_right,
        input  o_score_left, o_score_right, o_ball_enable, o_ball_reset,
        input  o_serve_right, o_point_pulse, o_game_over, o_winner_right
    );

    modport slave (
        input  i_timing_tick, i_start_btn, i_miss_left, i_miss_right,
        output o_score_left, o_score_right, o_ball_enable, o_ball_reset,
        output o_serve_right, o_point_pulse, o_game_over, o_winner_right
    );
endinterface

// File: rtl/game_score_fsm.sv
// Match sequencer: idle, serve countdown, play, game over.
// Keeps both scores and drives the ball block and score renderer.
module game_score_fsm #(
    parameter int WIN_SCORE   = 9,
    parameter int SCORE_W     = 4,
    parameter int SERVE_TICKS = 60,
    parameter int CNT_W       = 8
) (
    input  logic         clk,
    input  logic         rst,
    game_score_if.slave  bus
);

    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t             r_state;
    logic [SCORE_W-1:0] r_score_left;
    logic [SCORE_W-1:0] r_score_right;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_serve_right;
    logic               r_point_pulse;
    logic               r_winner_right;
    logic               r_ball_enable;
    logic               r_ball_reset;
    logic               r_game_over;
    logic               r_start_q;
    // Set once the button has been seen low after reset, so a button
    // held through reset cannot start a match on its own.
    logic               r_armed;

    logic               w_start_evt;
    logic               w_miss_valid;
    logic [SCORE_W-1:0] w_left_next;
    logic [SCORE_W-1:0] w_right_next;

    assign w_start_evt  = bus.i_start_btn & ~r_start_q & r_armed;
    assign w_miss_valid = bus.i_miss_left ^ bus.i_miss_right;
    assign w_left_next  = r_score_left + 1'b1;
    assign w_right_next = r_score_right + 1'b1;

    // Match state machine with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_score_left   <= '0;
            r_score_right  <= '0;
            r_cnt          <= '0;
            r_serve_right  <= 1'b1;
            r_point_pulse  <= 1'b0;
            r_winner_right <= 1'b0;
            r_ball_enable  <= 1'b0;
            r_ball_reset   <= 1'b1;
            r_game_over    <= 1'b0;
            r_start_q      <= 1'b0;
            r_armed        <= 1'b0;
        end else begin
            r_start_q     <= bus.i_start_btn;
            r_point_pulse <= 1'b0;
            if (!bus.i_start_btn) begin
                r_armed <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_start_evt) begin
                        r_state       <= S_SERVE;
                        r_score_left  <= '0;
                        r_score_right <= '0;
                        r_cnt         <= '0;
                    end
                end
                S_SERVE: begin
                    if (bus.i_timing_tick) begin
                        if (r_cnt == SERVE_LAST) begin
                            r_cnt         <= '0;
                            r_state       <= S_PLAY;
                            r_ball_enable <= 1'b1;
                            r_ball_reset  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_PLAY: begin
                    if (w_miss_valid) begin
                        r_point_pulse <= 1'b1;
                        r_ball_enable <= 1'b0;
                        r_ball_reset  <= 1'b1;
                        r_cnt         <= '0;
                        if (bus.i_miss_right) begin
                            r_score_left  <= w_left_next;
                            r_serve_right <= 1'b1;
                            if (w_left_next == WIN_VAL) begin
                                r_state        <= S_OVER;
                                r_game_over    <= 1'b1;
                                r_winner_right <= 1'b0;
                            end else begin
                                r_state <= S_SERVE;
                            end
                        end else begin
                            r_score_right <= w_right_next;
                            r_serve_right <= 1'b0;
                            if (w_right_next == WIN_VAL) begin
                                r_state        <= S_OVER;
                                r_game_over    <= 1'b1;
                                r_winner_right <= 1'b1;
                            end else begin
                                r_state <= S_SERVE;
                            end
                        end
                    end
                end
                S_OVER: begin
                    if (w_start_evt) begin
                        r_state       <= S_SERVE;
                        r_score_left  <= '0;
                        r_score_right <= '0;
                        r_serve_right <= 1'b1;
                        r_game_over   <= 1'b0;
                        r_cnt         <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_score_left   = r_score_left;
    assign bus.o_score_right  = r_score_right;
    assign bus.o_ball_enable  = r_ball_enable;
    assign bus.o_ball_reset   = r_ball_reset;
    assign bus.o_serve_right  = r_serve_right;
    assign bus.o_point_pulse  = r_point_pulse;
    assign bus.o_game_over    = r_game_over;
    assign bus.o_winner_right = r_winner_right;

endmodule

// File: doc/game_score_fsm.md
Name: game_score_fsm

Overview:
- Game-flow controller downstream of the ball motion block.
- Consumes single-cycle miss pulses (ball left the court on the left or right side) and keeps both players' scores.
- Sequences the match through idle, serve countdown, play and game-over.
- Drives ball enable, ball recentre and serve direction back to the ball block, and feeds score and winner values to the on-screen score renderer.

Parameters:
- WIN_SCORE, 9, score that ends the match; must be ≤ 2**SCORE_W-1.
- SCORE_W, 4, width of each score counter.
- SERVE_TICKS, 60, number of timing_tick pulses spent in SERVE before play resumes (≈1 s at 60 Hz frame tick).
- CNT_W, 8, width of the serve tick counter; must hold SERVE_TICKS-1.

Ports:
- clk  in  1  system clock (pixel clock domain).
- rst  in  1  synchronous reset, active-high.
- timing_tick  in  1  one-cycle frame tick, same as used by the ball block.
- start_btn  in  1  start/restart request, level, already synchronised and debounced.
- miss_left  in  1  one-cycle pulse: ball exited the left edge (right player scores).
- miss_right  in  1  one-cycle pulse: ball exited the right edge (left player scores).
- score_left  out  SCORE_W  left player score.
- score_right  out  SCORE_W  right player score.
- ball_enable  out  1  high only in PLAY; ball block moves the ball only while high.
- ball_reset  out  1  high in IDLE, SERVE and OVER; ball block holds the ball at centre.
- serve_right  out  1  direction of the next serve: 1 = toward the right player, 0 = toward the left player.
- point_pulse  out  1  one-cycle pulse on every awarded point.
- game_over  out  1  high in OVER.
- winner_right  out  1  valid while game_over: 1 = right player won, 0 = left player won.

Behaviour:
- Clocking: all state is registered on posedge clk. Outputs are registered or decoded from the registered state only; no combinational path from inputs to outputs.
- Reset values:
  - state = IDLE; score_left = score_right = 0; serve counter = 0.
  - serve_right = 1; point_pulse = 0; winner_right = 0.
  - ball_enable = 0; ball_reset = 1; game_over = 0.
  - start edge-detect register = 0.
- Start detection: start_evt = start_btn & ~start_btn_q (rising edge). A button held through reset does not generate an event until it is released and pressed again.
- States:
  - IDLE: on start_evt, go to SERVE with scores cleared and the counter cleared.
  - SERVE: the counter increments on each timing_tick. On a timing_tick with counter == SERVE_TICKS-1, clear the counter and go to PLAY. ball_enable therefore rises exactly SERVE_TICKS ticks after SERVE entry.
  - PLAY: valid_miss = miss_left XOR miss_right.
    - miss_right alone: score_left+1, serve_right <= 1.
    - miss_left alone: score_right+1, serve_right <= 0.
    - In both cases point_pulse = 1 for the next cycle. If the new score == WIN_SCORE, go to OVER and set winner_right accordingly; otherwise go to SERVE with the counter cleared.
    - Both misses in the same cycle: no score change, no pulse, stay in PLAY.
  - OVER: scores frozen. On start_evt, clear scores, set serve_right <= 1 and go to SERVE.
- Miss pulses outside PLAY are ignored.
- start_evt outside IDLE/OVER is ignored.
- timing_tick outside SERVE is ignored.
- Latency: a miss in cycle N gives the updated score, point_pulse, ball_reset = 1 and ball_enable = 0 in cycle N+1.
- Scores never wrap: OVER is entered at WIN_SCORE, so no increment occurs beyond it.
- rst at any time, including mid-SERVE or mid-PLAY: all reset values apply on the next edge.

Test Plan:
- Reset then idle 100 cycles -> scores 0/0, ball_reset = 1, ball_enable = 0, serve_right = 1, game_over = 0.
- start_btn pulse, SERVE_TICKS = 60 -> ball_enable stays 0 through 59 ticks and goes to 1 one cycle after the 60th tick; ball_reset falls in the same cycle.
- In PLAY, miss_right pulse -> next cycle score_left = 1, point_pulse = 1 for exactly one cycle, serve_right = 1, state SERVE. Then miss_left after the next serve -> score_right = 1, serve_right = 0.
- Left player scores 9 times (WIN_SCORE = 9) -> after the 9th miss_right, game_over = 1, winner_right = 0, score_left = 9. Further miss pulses leave the scores unchanged. start_btn -> scores 0/0, SERVE, serve_right = 1.
- Simultaneous miss_left and miss_right in PLAY -> no score change, no point_pulse, still PLAY. Miss pulses during SERVE -> ignored.
- start_btn held through rst deassert -> no start. Assert rst at score 3/2 during PLAY -> next cycle everything returns to reset values.
